// File: rtl/dma_pkg.sv
// Shared types and constants for the single-channel word-copy DMA engine.
package dma_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } dma_state_t;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_START   = 0;
  localparam int CTRL_IRQ_CLR = 1;
  localparam int CTRL_ABORT   = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
endpackage

// File: rtl/dma_controller.sv
// Word-copy DMA: a memory-mapped slave for setup, and a req/gnt bus master that
// alternates one read and one write per word until LEN reaches zero.
module dma_controller
  import dma_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic [1:0]           reg_sel,
  input  logic [31:0]          wdata,
  input  logic                 wenable,
  output logic [31:0]          rdata,
  output logic                 m_req,
  output logic [31:0]          m_addr,
  output logic [31:0]          m_wdata,
  output logic [3:0]           m_wenable,
  input  logic                 m_gnt,
  input  logic [31:0]          m_rdata,
  output logic                 irq
);

  dma_state_t           r_state;
  dma_state_t           w_state_next;
  logic [31:0]          r_src;
  logic [31:0]          r_dst;
  logic [31:0]          r_buf;
  logic [LEN_WIDTH-1:0] r_len;
  logic                 r_done;

  logic w_ctrl_wr;
  logic w_start;
  logic w_irq_clr;
  logic w_abort;
  logic w_idle;
  logic w_go;
  logic w_len_zero;
  logic w_rd_gnt;
  logic w_wr_gnt;
  logic w_last_wr;
  logic w_set_done;
  logic w_unused;

  assign w_ctrl_wr  = wenable && (reg_sel == REG_CTRL);
  assign w_start    = w_ctrl_wr && wdata[CTRL_START];
  assign w_irq_clr  = w_ctrl_wr && wdata[CTRL_IRQ_CLR];
  assign w_abort    = w_ctrl_wr && wdata[CTRL_ABORT];
  assign w_idle     = (r_state == ST_IDLE);
  // START together with ABORT while idle is a no-op, including the LEN=0 case.
  assign w_go       = w_idle && w_start && !w_abort;
  assign w_len_zero = (r_len == '0);
  assign w_rd_gnt   = (r_state == ST_READ) && m_gnt;
  assign w_wr_gnt   = (r_state == ST_WRITE) && m_gnt;
  assign w_last_wr  = w_wr_gnt && (r_len == LEN_WIDTH'(1)) && !w_abort;
  assign w_set_done = w_last_wr || (w_go && w_len_zero);
  assign w_unused   = ^wdata[31:LEN_WIDTH];

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_go && !w_len_zero) w_state_next = ST_READ;
      end
      ST_READ: begin
        if (w_abort)    w_state_next = ST_IDLE;
        else if (m_gnt) w_state_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (w_abort)        w_state_next = ST_IDLE;
        else if (w_last_wr) w_state_next = ST_IDLE;
        else if (m_gnt)     w_state_next = ST_READ;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    m_req     = 1'b0;
    m_addr    = r_src;
    m_wenable = 4'h0;
    case (r_state)
      ST_READ: m_req = 1'b1;
      ST_WRITE: begin
        m_req     = 1'b1;
        m_addr    = r_dst;
        m_wenable = 4'hF;
      end
      default: ;
    endcase
  end

  // A write granted in the same cycle as ABORT did reach memory, so it still advances the pointers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src  <= '0;
      r_dst  <= '0;
      r_len  <= '0;
      r_buf  <= '0;
      r_done <= 1'b0;
    end else begin
      if (w_idle && wenable) begin
        case (reg_sel)
          REG_SRC: r_src <= {wdata[31:2], 2'b00};
          REG_DST: r_dst <= {wdata[31:2], 2'b00};
          REG_LEN: r_len <= wdata[LEN_WIDTH-1:0];
          default: ;
        endcase
      end
      if (w_rd_gnt) r_buf <= m_rdata;
      if (w_wr_gnt) begin
        r_src <= r_src + 32'd4;
        r_dst <= r_dst + 32'd4;
        r_len <= r_len - LEN_WIDTH'(1);
      end
      if (w_set_done)                r_done <= 1'b1;
      else if (w_go || w_irq_clr)    r_done <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_SRC: rdata = r_src;
      REG_DST: rdata = r_dst;
      REG_LEN: rdata = 32'(r_len);
      default: begin
        rdata[STAT_BUSY] = !w_idle;
        rdata[STAT_DONE] = r_done;
      end
    endcase
  end

  assign m_wdata = r_buf;
  assign irq     = r_done;

endmodule
